basic_loops_feeder: RTL and testbench

Host-side feeder and collector for the `basic_loops` HLS core (ap_ctrl_hs, single-port array `A`, 13-bit `ap_return`).
- Upstream: accepts a byte stream and fills a local 16×8 array.
- Serves the core's `A_address0`/`A_ce0` read port with `A_q0`.
- Runs one start/done handshake per array, captures `ap_return`, and presents it on a valid/ready result port.
- Sits between the emulation transactor or host stream and the core, so a full array→result transaction needs no per-cycle host involvement.

---
 rtl/basic_loops_feeder_pkg.sv | 19 +
 rtl/feeder_array_ram.sv | 40 ++++
 rtl/basic_loops_feeder.sv | 125 ++++++++++++
 tb/tb_basic_loops_feeder.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/basic_loops_feeder_pkg.sv
// Shared definitions for the basic_loops feeder: controller states and the
// default geometry of the array handed to the basic_loops core.
package basic_loops_feeder_pkg;

    localparam int DEPTH_DEF = 16;  // array entries
    localparam int AW_DEF    = 4;   // core address width
    localparam int DW_DEF    = 8;   // element width
    localparam int RW_DEF    = 13;  // ap_return width

    // LOAD: filling the array, START: ap_start raised, RUN: waiting for done,
    // OUT: result held on the result port.
    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        OUT   = 2'd3
    } state_t;

endpackage

// File: rtl/feeder_array_ram.sv
// DEPTH x DW register array: one write port driven by the load side and one
// registered read port with clock enable that serves the core's A port.
module feeder_array_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          ce,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] q
);

    logic [DW-1:0] mem [DEPTH];

    // Write port: contents are never cleared, every entry is rewritten before use.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: one-cycle latency, holds when ce is low, zero for addresses past the array.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (ce) begin
            if ({1'b0, raddr} < (AW+1)'(DEPTH)) begin
                q <= mem[raddr];
            end else begin
                q <= '0;
            end
        end
    end

endmodule

// File: rtl/basic_loops_feeder.sv
// Feeder/collector for the basic_loops HLS core: loads a byte array from a
// stream, serves the core's array read port, runs one ap_ctrl_hs start/done
// handshake per array and presents ap_return on a result port.
//
// Handshakes: a stream beat moves on every cycle where valid and ready are
// both high at the clock edge; valid, once raised, stays high with stable
// data until that edge, and ready may depend combinationally on state only.
module basic_loops_feeder
    import basic_loops_feeder_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF,
    parameter int RW    = RW_DEF
) (
    input  logic          ap_clk,
    input  logic          ap_rst,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [RW-1:0] m_result,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          ap_start,
    input  logic          ap_done,
    input  logic          ap_idle,
    input  logic          ap_ready,
    input  logic [AW-1:0] A_address0,
    input  logic          A_ce0,
    output logic [DW-1:0] A_q0,
    input  logic [RW-1:0] ap_return,
    output logic          busy,
    output logic [AW:0]   fill_cnt,
    output state_t        dbg_state,
    output logic          dbg_core_idle
);

    state_t        state_q;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   fill_q;
    logic          accept;
    logic          last_accept;

    assign s_ready       = (state_q == LOAD) & ~ap_rst;
    assign accept        = s_valid & s_ready;
    assign last_accept   = accept & (fill_q == (AW+1)'(DEPTH - 1));
    assign busy          = (state_q != LOAD);
    assign fill_cnt      = fill_q;
    assign dbg_state     = state_q;
    // The core's idle flag is status only; it is passed through for observation.
    assign dbg_core_idle = ap_idle;

    feeder_array_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_ram (
        .clk   (ap_clk),
        .rst   (ap_rst),
        .we    (accept),
        .waddr (wr_ptr),
        .wdata (s_data),
        .ce    (A_ce0),
        .raddr (A_address0),
        .q     (A_q0)
    );

    // Transaction controller: load, start handshake, wait for done, hold result.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q  <= LOAD;
            wr_ptr   <= '0;
            fill_q   <= '0;
            ap_start <= 1'b0;
            m_valid  <= 1'b0;
            m_result <= '0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (accept) begin
                        wr_ptr <= wr_ptr + AW'(1);
                        fill_q <= fill_q + (AW+1)'(1);
                        if (last_accept) begin
                            state_q  <= START;
                            ap_start <= 1'b1;
                        end
                    end
                end
                START: begin
                    // ap_start stays up until the core reports ap_ready.
                    if (ap_ready) begin
                        ap_start <= 1'b0;
                        if (ap_done) begin
                            m_result <= ap_return;
                            m_valid  <= 1'b1;
                            state_q  <= OUT;
                        end else begin
                            state_q  <= RUN;
                        end
                    end
                end
                RUN: begin
                    // ap_return is only meaningful in the ap_done cycle.
                    if (ap_done) begin
                        m_result <= ap_return;
                        m_valid  <= 1'b1;
                        state_q  <= OUT;
                    end
                end
                OUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        wr_ptr  <= '0;
                        fill_q  <= '0;
                        state_q <= LOAD;
                    end
                end
                default: begin
                    state_q <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_basic_loops_feeder.sv
// Self-checking bench for basic_loops_feeder with a small behavioural model
// of the core on the other side of the feeder.
module tb_basic_loops_feeder;
    import basic_loops_feeder_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int RW    = 13;

    // ---------------- clock / reset / DUT ----------------
    logic          ap_clk = 1'b0;
    logic          ap_rst;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [RW-1:0] m_result;
    logic          m_valid;
    logic          m_ready;
    logic          ap_start;
    logic          ap_done;
    logic          ap_idle;
    logic          ap_ready;
    logic [AW-1:0] A_address0;
    logic          A_ce0;
    logic [DW-1:0] A_q0;
    logic [RW-1:0] ap_return;
    logic          busy;
    logic [AW:0]   fill_cnt;
    state_t        dbg_state;
    logic          dbg_core_idle;

    always #5 ap_clk = ~ap_clk;

    basic_loops_feeder #(
        .DEPTH (DEPTH), .AW (AW), .DW (DW), .RW (RW)
    ) dut (
        .ap_clk        (ap_clk),
        .ap_rst        (ap_rst),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .m_result      (m_result),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .ap_start      (ap_start),
        .ap_done       (ap_done),
        .ap_idle       (ap_idle),
        .ap_ready      (ap_ready),
        .A_address0    (A_address0),
        .A_ce0         (A_ce0),
        .A_q0          (A_q0),
        .ap_return     (ap_return),
        .busy          (busy),
        .fill_cnt      (fill_cnt),
        .dbg_state     (dbg_state),
        .dbg_core_idle (dbg_core_idle)
    );

    // ---------------- scoreboard ----------------
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [RW-1:0] exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    // Transaction view: the array is either being filled, owned by the core
    // (with or without the start acknowledged), or a result is waiting.
    bit            md_started = 0;
    bit            md_loading;
    bit            md_core;
    bit            md_ack_seen;
    bit            md_res_valid;
    int            md_cnt;
    logic [RW-1:0] md_result;
    logic [DW-1:0] md_aq0;
    logic [DW-1:0] md_mem [DEPTH];

    always @(posedge ap_clk) begin
        md_started <= 1'b1;
        if (ap_rst) begin
            md_loading   <= 1'b1;
            md_core      <= 1'b0;
            md_ack_seen  <= 1'b0;
            md_res_valid <= 1'b0;
            md_cnt       <= 0;
            md_result    <= '0;
            md_aq0       <= '0;
        end else begin
            if (A_ce0) md_aq0 <= (int'(A_address0) < DEPTH) ? md_mem[A_address0] : '0;
            if (md_loading && s_valid) begin
                md_mem[md_cnt] <= s_data;
                md_cnt         <= md_cnt + 1;
                if (md_cnt == DEPTH - 1) begin
                    md_loading  <= 1'b0;
                    md_core     <= 1'b1;
                    md_ack_seen <= 1'b0;
                end
            end
            if (md_core) begin
                if (ap_ready) md_ack_seen <= 1'b1;
                if (ap_done && (md_ack_seen || ap_ready)) begin
                    md_core      <= 1'b0;
                    md_res_valid <= 1'b1;
                    md_result    <= ap_return;
                end
            end
            if (md_res_valid && m_ready) begin
                md_res_valid <= 1'b0;
                md_loading   <= 1'b1;
                md_cnt       <= 0;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge ap_clk) begin
        if (md_started) begin
            chk("s_ready",  s_ready,  md_loading && !ap_rst);
            chk("busy",     busy,     !md_loading);
            chk("ap_start", ap_start, md_core && !md_ack_seen);
            chk("m_valid",  m_valid,  md_res_valid);
            chk("m_result", m_result, md_result);
            chk("fill_cnt", fill_cnt, md_cnt);
            chk("A_q0",     A_q0,     md_aq0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic rand_array(output logic [DW-1:0] d [DEPTH]);
        for (int i = 0; i < DEPTH; i++) d[i] = DW'($urandom);
    endtask

    task automatic load_array(input logic [DW-1:0] d [DEPTH], input bit throttle);
        logic [RW-1:0] sum;
        sum = '0;
        for (int i = 0; i < DEPTH; i++) begin
            int t;
            t = 0;
            while (s_ready !== 1'b1 && t < 100) begin step(); t++; end
            if (t >= 100) begin
                chk("load_wait_timeout", s_ready, 1);
                return;
            end
            if (throttle) begin
                s_valid = 1'b0;
                s_data  = DW'($urandom);
                step();
            end
            s_valid = 1'b1;
            s_data  = d[i];
            sum     = sum + RW'(d[i]);
            step();
            s_valid = 1'b0;
            chk("load_fill_cnt", fill_cnt, i + 1);
            if (i < DEPTH - 1) chk("no_early_start", ap_start, 0);
        end
        exp_q.push_back(sum);
        chk("start_after_last", ap_start, 1);
    endtask

    // Core model: acknowledge start, read every address, return the sum.
    task automatic run_core(input bit same_cycle);
        int            t;
        logic [RW-1:0] acc;
        t = 0;
        while (ap_start !== 1'b1 && t < 100) begin step(); t++; end
        if (t >= 100) begin
            chk("core_start_timeout", ap_start, 1);
            return;
        end
        ap_idle = 1'b0;
        if (!same_cycle) begin
            repeat ($urandom_range(0, 3)) step();
            chk("start_held", ap_start, 1);
            ap_ready = 1'b1;
            step();
            ap_ready = 1'b0;
        end
        acc = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                A_ce0      = 1'b0;
                A_address0 = AW'($urandom);
                step();
            end
            A_ce0      = 1'b1;
            A_address0 = AW'(i);
            ap_return  = RW'($urandom);
            step();
            acc = acc + RW'(A_q0);
        end
        A_ce0     = 1'b0;
        ap_return = acc;
        ap_done   = 1'b1;
        if (same_cycle) ap_ready = 1'b1;
        step();
        ap_done   = 1'b0;
        ap_ready  = 1'b0;
        ap_return = RW'($urandom);
        ap_idle   = 1'b1;
        chk("start_low_after_done", ap_start, 0);
        chk("m_valid_after_done",   m_valid,  1);
    endtask

    task automatic drain(input int bp, input bit keep_ready, output logic [RW-1:0] got);
        int            t;
        logic [RW-1:0] held;
        logic [RW-1:0] exp;
        got = '0;
        t = 0;
        while (m_valid !== 1'b1 && t < 100) begin step(); t++; end
        if (t >= 100) begin
            chk("result_timeout", m_valid, 1);
            return;
        end
        chk("s_ready_low_in_out", s_ready, 0);
        if (bp > 0) begin
            m_ready = 1'b0;
            held    = m_result;
            for (int i = 0; i < bp; i++) begin
                s_valid = 1'b1;
                s_data  = DW'($urandom);
                step();
                chk("bp_m_valid",  m_valid,  1);
                chk("bp_m_result", m_result, held);
                chk("bp_s_ready",  s_ready,  0);
            end
            s_valid = 1'b0;
        end
        m_ready = 1'b1;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", exp_q.size(), 1);
            exp = '0;
        end else begin
            exp = exp_q.pop_front();
        end
        chk("result", m_result, exp);
        got = m_result;
        step();
        chk("reentry_s_ready", s_ready, 1);
        chk("m_valid_cleared", m_valid, 0);
        if (!keep_ready) m_ready = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [DW-1:0] d [DEPTH];
        logic [RW-1:0] got;
        int            t;

        ap_rst     = 1'b1;
        s_data     = '0;
        s_valid    = 1'b0;
        m_ready    = 1'b0;
        ap_done    = 1'b0;
        ap_idle    = 1'b1;
        ap_ready   = 1'b0;
        A_address0 = '0;
        A_ce0      = 1'b0;
        ap_return  = '0;
        repeat (3) step();
        chk("rst_s_ready",  s_ready,  0);
        chk("rst_ap_start", ap_start, 0);
        chk("rst_m_valid",  m_valid,  0);
        chk("rst_m_result", m_result, 0);
        chk("rst_A_q0",     A_q0,     0);
        chk("rst_fill_cnt", fill_cnt, 0);
        chk("rst_busy",     busy,     0);
        ap_rst = 1'b0;
        step();

        // Basic run: 0x01..0x10 sums to 136.
        for (int i = 0; i < DEPTH; i++) d[i] = DW'(i + 1);
        load_array(d, 1'b0);
        run_core(1'b0);
        drain(0, 1'b0, got);
        chk("basic_result_literal", got, 13'h088);

        // Throttled load of all 0xFF.
        for (int i = 0; i < DEPTH; i++) d[i] = 8'hFF;
        load_array(d, 1'b1);
        chk("throttle_fill_16", fill_cnt, 16);
        chk("throttle_busy", busy, 1);
        run_core(1'b0);
        drain(0, 1'b0, got);
        chk("throttle_result_literal", got, 13'hFF0);

        // ap_ready and ap_done in the same cycle.
        rand_array(d);
        load_array(d, 1'b0);
        run_core(1'b1);
        drain(0, 1'b0, got);

        // Output backpressure for 20 cycles with s_valid pushing.
        rand_array(d);
        load_array(d, 1'b0);
        run_core(1'($urandom_range(0, 1)));
        drain(20, 1'b0, got);

        // Reset in the middle of the core run.
        rand_array(d);
        load_array(d, 1'b0);
        t = 0;
        while (ap_start !== 1'b1 && t < 100) begin step(); t++; end
        chk("midrun_start_seen", ap_start, 1);
        ap_ready = 1'b1;
        step();
        ap_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            A_ce0      = 1'b1;
            A_address0 = AW'(i);
            step();
        end
        ap_rst = 1'b1;
        step();
        chk("midrst_busy",     busy,     0);
        chk("midrst_ap_start", ap_start, 0);
        chk("midrst_m_valid",  m_valid,  0);
        chk("midrst_A_q0",     A_q0,     0);
        chk("midrst_fill_cnt", fill_cnt, 0);
        chk("midrst_s_ready",  s_ready,  0);
        ap_rst = 1'b0;
        A_ce0  = 1'b0;
        exp_q.delete();
        #1;
        chk("postrst_s_ready", s_ready, 1);
        for (int i = 0; i < DEPTH; i++) d[i] = 8'h02;
        load_array(d, 1'b0);
        run_core(1'b0);
        drain(0, 1'b0, got);
        chk("postrst_result_literal", got, 13'h020);

        // Back-to-back with m_ready held high.
        m_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rand_array(d);
            load_array(d, 1'b0);
            run_core(1'b0);
            drain(0, 1'b1, got);
        end
        m_ready = 1'b0;

        // Randomised transactions.
        for (int k = 0; k < 6; k++) begin
            rand_array(d);
            load_array(d, 1'($urandom_range(0, 1)));
            run_core(1'($urandom_range(0, 1)));
            drain(($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 8)) : 0, 1'b0, got);
        end

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound.
    initial begin
        #400000;
        n_fail++;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
